// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory write path.
package imem_pkg;

    localparam int          IMEM_DEPTH    = 32;
    localparam int          IMEM_ADDR_W   = 5;
    localparam logic [31:0] IMEM_OOR_DATA = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } imem_wr_state_t;

endpackage

// File: rtl/imem_store.sv
// Flop array backing the instruction memory: one synchronous write port,
// synchronous clear, and a combinational word-indexed read port.
module imem_store
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [63:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [DATA_W-1:0] OOR_DATA = DATA_W'(IMEM_OOR_DATA);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every slot on reset, otherwise write one word per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Full-width range check so aliased high bits never hit a real slot.
    always_comb begin
        rd_data = OOR_DATA;
        if (rd_addr <= 64'(DEPTH - 1)) begin
            rd_data = mem[rd_addr[ADDR_W-1:0]];
        end
    end

endmodule

// File: rtl/imem_writer.sv
// Burst loader for the instruction memory: validates a start request,
// streams words into consecutive slots and reports completion or rejection.
module imem_writer
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [63:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    imem_wr_state_t    state, state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   remaining;
    logic              err_q;
    logic [ADDR_W+1:0] burst_end;
    logic              start_ok;
    logic              start_bad;
    logic              hs;

    // Two extra bits so base + count can never wrap before the range check.
    assign burst_end = {2'b00, base_addr} + {1'b0, count};
    assign hs        = in_valid & in_ready;
    assign err       = err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and state-derived outputs; in_ready depends on state only.
    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0 && burst_end <= (ADDR_W+2)'(DEPTH)) begin
                        start_ok = 1'b1;
                        state_nx = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && remaining == (ADDR_W+1)'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Burst pointer, word counter and registered reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            remaining <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                wr_ptr    <= base_addr;
                remaining <= count;
            end else if (hs) begin
                wr_ptr    <= wr_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    imem_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .we      (hs),
        .waddr   (wr_ptr),
        .wdata   (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_imem_writer.sv
// Self-checking bench for imem_writer: a reference memory image drives a
// read scoreboard, control outputs are checked cycle by cycle.
module tb_imem_writer;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [63:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    imem_writer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a read address and queue the value the reference image predicts.
    task automatic rd_push(input logic [63:0] a);
        rd_addr = a;
        if (a > 64'(DEPTH - 1)) exp_q.push_back(32'hFFFFFFFF);
        else                    exp_q.push_back(model[a[ADDR_W-1:0]]);
    endtask

    task automatic rd_pop(input string tag);
        logic [DATA_W-1:0] e;
        #1;
        chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 64'(rd_data), 64'(e));
        end
    endtask

    task automatic rd_check(input string tag, input logic [63:0] a);
        rd_push(a);
        rd_pop(tag);
    endtask

    task automatic ctl(input string tag, input logic r, input logic b, input logic d, input logic e);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(r));
        chk({tag, "_busy"},     64'(busy),     64'(b));
        chk({tag, "_done"},     64'(done),     64'(d));
        chk({tag, "_err"},      64'(err),      64'(e));
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        step();
        start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] w1 [3];
        logic [4:0]        bad_base [3];
        logic [5:0]        bad_cnt  [3];
        w1[0] = 32'h00210783;
        w1[1] = 32'h007782B3;
        w1[2] = 32'h00579423;
        bad_base[0] = 5'd31; bad_cnt[0] = 6'd2;
        bad_base[1] = 5'd0;  bad_cnt[1] = 6'd0;
        bad_base[2] = 5'd0;  bad_cnt[2] = 6'd33;

        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_data = '0; rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset state and read sweep.
        step(); step();
        reset = 1'b0;
        ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) rd_check("rst_rd", 64'(i));
        rd_check("rst_oor32", 64'd32);
        rd_check("rst_oor_max", 64'hFFFF_FFFF_FFFF_FFFF);
        rd_check("rst_alias", 64'h1_0000_0000);

        // Burst: base 0, count 3, continuous valid.
        step();
        do_start(5'd0, 6'd3);
        ctl("b1_c1", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = w1[i];
            rd_check("b1_old", 64'(i));
            step();
            model[i] = w1[i];
            rd_check("b1_new", 64'(i));
            if (i < 2) ctl("b1_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        // DONE cycle: offered word and start must both be ignored.
        ctl("b1_done", 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 32'hBAD0BAD0;
        start = 1'b1; base_addr = 5'd0; count = 6'd0;
        step();
        start = 1'b0; in_valid = 1'b0;
        ctl("b1_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd_check("b1_rd", 64'(i));

        // Burst: base 30, count 2, valid toggling 1/0/1.
        do_start(5'd30, 6'd2);
        ctl("b2_c1", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            in_valid = (j != 1);
            in_data  = (j != 1) ? (32'hA5A50000 + 32'(j)) : 32'hDEADBEEF;
            step();
            if (j != 1) model[30 + j / 2] = 32'hA5A50000 + 32'(j);
            if (j < 2) ctl("b2_mid", 1'b1, 1'b1, 1'b0, 1'b0);
            else       ctl("b2_done", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        step();
        ctl("b2_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 29; i < 32; i++) rd_check("b2_rd", 64'(i));

        // Rejected starts.
        for (int k = 0; k < 3; k++) begin
            do_start(bad_base[k], bad_cnt[k]);
            ctl("rej_err", 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            ctl("rej_after", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rd_check("rej_rd0", 64'd0);
        rd_check("rej_rd31", 64'd31);

        // Reset in the middle of a burst, with a handshake offered that cycle.
        do_start(5'd4, 6'd4);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h11110000 + 32'(i);
            step();
            model[4 + i] = 32'h11110000 + 32'(i);
        end
        rd_check("mid_rd4", 64'd4);
        in_data = 32'h22222222;
        reset   = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        ctl("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rd_check("mid_rd4z", 64'd4);
        rd_check("mid_rd5z", 64'd5);
        rd_check("mid_rd6z", 64'd6);
        rd_check("mid_rd0z", 64'd0);
        step();
        ctl("mid_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Start pulsed during LOAD is ignored.
        do_start(5'd8, 6'd3);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h33330000 + 32'(i);
            if (i == 1) begin
                start = 1'b1; base_addr = 5'd31; count = 6'd2;
            end
            step();
            start = 1'b0;
            model[8 + i] = 32'h33330000 + 32'(i);
            if (i < 2) ctl("ign_mid", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        ctl("ign_done", 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        ctl("ign_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i < 12; i++) rd_check("ign_rd", 64'(i));
        rd_check("ign_rd31", 64'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
